// File: rtl/ascon_pack.sv
// ascon_pack: shared widths and collector state encoding for the ASCON output path.
// Rev 1.0
`default_nettype none

package ascon_pack;

  localparam int BLOCK_W         = 64;
  localparam int TAG_W           = 128;
  localparam int OUT_W           = 32;
  localparam int WORDS_PER_BLOCK = BLOCK_W / OUT_W;
  localparam int WORDS_PER_TAG   = TAG_W / OUT_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    TAG_WAIT = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } collector_state_t;

endpackage

`default_nettype wire

// File: rtl/cipher_block_buffer.sv
// cipher_block_buffer: NB_BLOCKS x BLOCK_W register file, one write port, word-select read port.
// Rev 1.0
`default_nettype none

module cipher_block_buffer #(
  parameter int NB_BLOCKS  = 4,
  parameter int BLOCK_W    = 64,
  parameter int OUT_W      = 32,
  localparam int C_AW      = $clog2(NB_BLOCKS),
  localparam int C_WPB     = BLOCK_W / OUT_W,
  localparam int C_SW      = $clog2(C_WPB)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [C_AW-1:0]    i_wr_addr,
  input  logic [BLOCK_W-1:0] i_wr_data,
  input  logic [C_AW-1:0]    i_rd_addr,
  input  logic [C_SW-1:0]    i_rd_word,
  output logic [OUT_W-1:0]   o_rd_data
);

  logic [BLOCK_W-1:0] r_mem [NB_BLOCKS];
  logic [BLOCK_W-1:0] w_blk;
  logic [OUT_W-1:0]   w_words [C_WPB];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign w_blk = r_mem[i_rd_addr];

  // Word 0 is the most significant slice of the block.
  for (genvar g = 0; g < C_WPB; g++) begin : g_word
    assign w_words[g] = w_blk[BLOCK_W-1-g*OUT_W -: OUT_W];
  end

  assign o_rd_data = w_words[i_rd_word];

endmodule

`default_nettype wire

// File: rtl/cipher_block_collector.sv
// cipher_block_collector: captures ciphertext blocks and tag, drains them as OUT_W-bit words.
// Optional CIPHER_COLLECTOR_TAG_VERIFY_EN compares the tag instead of streaming it. Rev 1.0
`default_nettype none

module cipher_block_collector #(
  parameter int NB_BLOCKS = 4,
  parameter int BLOCK_W   = ascon_pack::BLOCK_W,
  parameter int OUT_W     = ascon_pack::OUT_W
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic                         cipher_valid_i,
  input  logic [BLOCK_W-1:0]           cipher_i,
  input  logic                         tag_valid_i,
  input  logic [ascon_pack::TAG_W-1:0] tag_i,
  input  logic                         out_ready_i,
  output logic                         out_valid_o,
  output logic [OUT_W-1:0]             out_data_o,
  output logic                         out_last_o,
  output logic                         out_is_tag_o,
  output logic [$clog2(NB_BLOCKS)-1:0] cpt_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
  ,
  input  logic [ascon_pack::TAG_W-1:0] expected_tag_i,
  output logic                         tag_ok_o
`endif
);

  import ascon_pack::*;

  localparam int c_aw    = $clog2(NB_BLOCKS);
  localparam int c_cnt_w = $clog2(NB_BLOCKS + 1);
  localparam int c_wpb   = BLOCK_W / OUT_W;
  localparam int c_sw    = $clog2(c_wpb);
  localparam int c_wpt   = TAG_W / OUT_W;
  localparam int c_ptr_w = $clog2(NB_BLOCKS * c_wpb + c_wpt + 1);

  collector_state_t     r_state, w_next_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_ptr_w-1:0]   r_ptr;
  logic                 r_overflow;
  logic                 w_wr_en;
  logic                 w_tag_cap;
  logic                 w_fire;
  logic                 w_last;
  logic [c_cnt_w-1:0]   w_cnt_after;
  logic [c_ptr_w-1:0]   w_blk_words;
  logic [OUT_W-1:0]     w_blk_word;
  logic [OUT_W-1:0]     w_word;
  logic                 w_is_tag;

  assign w_wr_en     = (r_state == COLLECT) && cipher_valid_i;
  assign w_tag_cap   = tag_valid_i && ((r_state == COLLECT) || (r_state == TAG_WAIT));
  assign w_fire      = (r_state == DRAIN) && out_ready_i;
  assign w_cnt_after = w_wr_en ? r_cnt + c_cnt_w'(1) : r_cnt;
  assign w_blk_words = c_ptr_w'(r_cnt * c_wpb);

  cipher_block_buffer #(
    .NB_BLOCKS (NB_BLOCKS),
    .BLOCK_W   (BLOCK_W),
    .OUT_W     (OUT_W)
  ) u_buffer (
    .clk       (clock_i),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_cnt[c_aw-1:0]),
    .i_wr_data (cipher_i),
    .i_rd_addr (r_ptr[c_sw +: c_aw]),
    .i_rd_word (r_ptr[c_sw-1:0]),
    .o_rd_data (w_blk_word)
  );

`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
  logic r_tag_ok;

  assign w_last   = (r_ptr == w_blk_words - c_ptr_w'(1));
  assign w_is_tag = 1'b0;
  assign w_word   = w_blk_word;
  assign tag_ok_o = r_tag_ok;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_tag_ok <= 1'b0;
    end else if ((r_state == IDLE) && start_i) begin
      r_tag_ok <= 1'b0;
    end else if (w_tag_cap) begin
      r_tag_ok <= (tag_i == expected_tag_i);
    end
  end
`else
  localparam int c_tw = $clog2(c_wpt);

  logic [TAG_W-1:0] r_tag;
  logic [OUT_W-1:0] w_tag_words [c_wpt];
  logic [c_tw-1:0]  w_tag_sel;

  always_ff @(posedge clock_i) begin
    if (w_tag_cap) begin
      r_tag <= tag_i;
    end
  end

  for (genvar g = 0; g < c_wpt; g++) begin : g_tag_word
    assign w_tag_words[g] = r_tag[TAG_W-1-g*OUT_W -: OUT_W];
  end

  // Tag words follow the ciphertext words in the read pointer space.
  assign w_is_tag  = (r_ptr >= w_blk_words);
  assign w_tag_sel = c_tw'(r_ptr - w_blk_words);
  assign w_word    = w_is_tag ? w_tag_words[w_tag_sel] : w_blk_word;
  assign w_last    = (r_ptr == w_blk_words + c_ptr_w'(c_wpt - 1));
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) w_next_state = COLLECT;
      end
      COLLECT: begin
        if (tag_valid_i) begin
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
          w_next_state = (w_cnt_after == '0) ? DONE : DRAIN;
`else
          w_next_state = DRAIN;
`endif
        end else if (w_cnt_after == c_cnt_w'(NB_BLOCKS)) begin
          w_next_state = TAG_WAIT;
        end
      end
      TAG_WAIT: begin
        if (tag_valid_i) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (w_fire && w_last) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == IDLE) && start_i) begin
        r_cnt      <= '0;
        r_ptr      <= '0;
        r_overflow <= 1'b0;
      end
      if (w_wr_en) begin
        r_cnt <= w_cnt_after;
      end
      if ((r_state == TAG_WAIT) && cipher_valid_i) begin
        r_overflow <= 1'b1;
      end
      if (w_fire && !w_last) begin
        r_ptr <= r_ptr + c_ptr_w'(1);
      end
    end
  end

  assign out_valid_o  = (r_state == DRAIN);
  assign out_data_o   = out_valid_o ? w_word : '0;
  assign out_last_o   = out_valid_o && w_last;
  assign out_is_tag_o = out_valid_o && w_is_tag;
  assign cpt_o        = r_cnt[c_aw-1:0];
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);
  assign overflow_o   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cipher_block_collector.sv
// tb_cipher_block_collector: scoreboard bench for cipher_block_collector.
// Honours CIPHER_COLLECTOR_TAG_VERIFY_EN when the design is built with it. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_cipher_block_collector;

  typedef struct packed {
    logic [31:0] d;
    logic        t;
    logic        l;
  } word_t;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic          cipher_valid_i = 1'b0;
  logic [63:0]   cipher_i = '0;
  logic          tag_valid_i = 1'b0;
  logic [127:0]  tag_i = '0;
  logic          out_ready_i = 1'b0;
  logic          out_valid_o;
  logic [31:0]   out_data_o;
  logic          out_last_o;
  logic          out_is_tag_o;
  logic [1:0]    cpt_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
  logic [127:0]  expected_tag_i = '0;
  logic          tag_ok_o;
`endif

  localparam logic [63:0]  B0  = 64'h0123456789ABCDEF;
  localparam logic [63:0]  B1  = 64'hFEDCBA9876543210;
  localparam logic [127:0] TAG = 128'h00112233445566778899AABBCCDDEEFF;

  word_t q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  cipher_block_collector dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .cipher_valid_i (cipher_valid_i),
    .cipher_i       (cipher_i),
    .tag_valid_i    (tag_valid_i),
    .tag_i          (tag_i),
    .out_ready_i    (out_ready_i),
    .out_valid_o    (out_valid_o),
    .out_data_o     (out_data_o),
    .out_last_o     (out_last_o),
    .out_is_tag_o   (out_is_tag_o),
    .cpt_o          (cpt_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
    ,
    .expected_tag_i (expected_tag_i),
    .tag_ok_o       (tag_ok_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  function automatic word_t mk(input logic [31:0] d, input logic t, input logic l);
    word_t w;
    w.d = d;
    w.t = t;
    w.l = l;
    return w;
  endfunction

  task automatic push_block(input logic [63:0] b);
    q.push_back(mk(b[63:32], 1'b0, 1'b0));
    q.push_back(mk(b[31:0], 1'b0, 1'b0));
  endtask

  task automatic push_tag(input logic [127:0] t);
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
    word_t w;
    if (q.size() > 0) begin
      w   = q.pop_back();
      w.l = 1'b1;
      q.push_back(w);
    end
`else
    logic [127:0] tv;
    tv = t;
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(tv[127-32*i -: 32], 1'b1, (i == 3)));
    end
`endif
  endtask

  task automatic do_start;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] b);
    cipher_valid_i = 1'b1;
    cipher_i       = b;
    tick();
    cipher_valid_i = 1'b0;
  endtask

  task automatic send_tag(input logic [127:0] t, input logic [127:0] expect_t);
    tag_valid_i = 1'b1;
    tag_i       = t;
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
    expected_tag_i = expect_t;
`else
    if (expect_t != t) $display("note: expected tag ignored in streaming build");
`endif
    tick();
    tag_valid_i = 1'b0;
  endtask

  // Consumes the queued words; the DUT must be in its first DRAIN cycle (or DONE).
  task automatic drain(input bit toggle);
    word_t       exp;
    logic [31:0] prev    = '0;
    bit          stalled = 1'b0;
    bit          rdy;
    int          cyc     = 0;
    while (q.size() > 0) begin
      if (cyc >= 64 || out_valid_o !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_valid: out_valid_o=%b at cycle %0d, %0d words still expected",
                 out_valid_o, cyc, q.size());
        q.delete();
        break;
      end
      exp = q[0];
      vectors++;
      if ({out_data_o, out_is_tag_o, out_last_o} !== exp) begin
        miscompares++;
        $display("FAIL drain_word: got data=%h tag=%b last=%b, expected data=%h tag=%b last=%b",
                 out_data_o, out_is_tag_o, out_last_o, exp.d, exp.t, exp.l);
      end
      if (stalled) begin
        vectors++;
        if (out_data_o !== prev) begin
          miscompares++;
          $display("FAIL drain_stable: got %h after stall, expected %h", out_data_o, prev);
        end
      end
      rdy         = toggle ? (cyc % 2 == 0) : 1'b1;
      out_ready_i = rdy;
      prev        = out_data_o;
      stalled     = !rdy;
      if (rdy) exp = q.pop_front();
      tick();
      cyc++;
    end
    out_ready_i = 1'b0;
    vectors++;
    if ({done_o, out_valid_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b valid=%b, expected done=1 valid=0", done_o, out_valid_o);
    end
    tick();
    vectors++;
    if ({done_o, busy_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL done_end: got done=%b busy=%b, expected 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    vectors++;
    if ({out_valid_o, out_last_o, out_is_tag_o, done_o, overflow_o, busy_o, cpt_o} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_flags: got v=%b l=%b t=%b d=%b o=%b b=%b c=%0d, expected all 0",
               out_valid_o, out_last_o, out_is_tag_o, done_o, overflow_o, busy_o, cpt_o);
    end
    vectors++;
    if (out_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, expected 00000000", out_data_o);
    end
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
    vectors++;
    if (tag_ok_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tag_ok: got %b, expected 0", tag_ok_o);
    end
`endif
  endtask

  task automatic test_reset_mid_drain;
    do_start();
    send_block(B0);
    send_block(B1);
    send_tag(TAG, TAG);
    out_ready_i = 1'b1;
    repeat (3) tick();
    out_ready_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    vectors++;
    if ({out_valid_o, cpt_o, busy_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_drain: got valid=%b cpt=%0d busy=%b, expected 0 0 0",
               out_valid_o, cpt_o, busy_o);
    end
    q.delete();
  endtask

  task automatic test_basic(input bit toggle);
    do_start();
    vectors++;
    if ({busy_o, cpt_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL start_state: got busy=%b cpt=%0d, expected busy=1 cpt=0", busy_o, cpt_o);
    end
    send_block(B0);
    push_block(B0);
    vectors++;
    if (cpt_o !== 2'd1) begin
      miscompares++;
      $display("FAIL cpt_one: got %0d, expected 1", cpt_o);
    end
    send_block(B1);
    push_block(B1);
    vectors++;
    if (cpt_o !== 2'd2) begin
      miscompares++;
      $display("FAIL cpt_two: got %0d, expected 2", cpt_o);
    end
    send_tag(TAG, TAG);
    push_tag(TAG);
    drain(toggle);
  endtask

  task automatic test_overflow;
    logic [63:0] blk;
    do_start();
    for (int i = 0; i < 4; i++) begin
      blk = {$urandom(), $urandom()};
      send_block(blk);
      push_block(blk);
    end
    vectors++;
    if ({cpt_o, overflow_o, busy_o} !== 4'b0001) begin
      miscompares++;
      $display("FAIL full_state: got cpt=%0d ovf=%b busy=%b, expected 0 0 1", cpt_o, overflow_o, busy_o);
    end
    send_block(64'hDEADBEEF_CAFEF00D);
    vectors++;
    if (overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: got %b, expected 1", overflow_o);
    end
    send_tag(TAG ^ 128'h5, TAG ^ 128'h5);
    push_tag(TAG ^ 128'h5);
    drain(1'b0);
    vectors++;
    if (overflow_o !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %b, expected 1", overflow_o);
    end
    do_start();
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: got %b, expected 0", overflow_o);
    end
    send_tag(TAG, TAG);
    push_tag(TAG);
    drain(1'b0);
  endtask

  task automatic test_zero_blocks;
    do_start();
    send_tag(~TAG, ~TAG);
    push_tag(~TAG);
    drain(1'b1);
`ifdef CIPHER_COLLECTOR_TAG_VERIFY_EN
    vectors++;
    if (tag_ok_o !== 1'b1) begin
      miscompares++;
      $display("FAIL tag_ok_match: got %b, expected 1", tag_ok_o);
    end
    do_start();
    send_block(B1);
    push_block(B1);
    send_tag(TAG, TAG ^ (128'h1 << 77));
    push_tag(TAG);
    drain(1'b0);
    vectors++;
    if (tag_ok_o !== 1'b0) begin
      miscompares++;
      $display("FAIL tag_ok_mismatch: got %b, expected 0", tag_ok_o);
    end
`endif
  endtask

  task automatic test_back_to_back;
    do_start();
    send_block(B1);
    push_block(B1);
    cipher_valid_i = 1'b1;
    cipher_i       = B0;
    send_tag(TAG, TAG);
    cipher_valid_i = 1'b0;
    push_block(B0);
    push_tag(TAG);
    vectors++;
    if ({out_valid_o, cpt_o} !== 3'b110) begin
      miscompares++;
      $display("FAIL same_cycle_cpt: got valid=%b cpt=%0d, expected valid=1 cpt=2", out_valid_o, cpt_o);
    end
    drain(1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_basic(1'b0);
    test_basic(1'b1);
    test_overflow();
    test_zero_blocks();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
